// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, types and operand classifier for the FP arithmetic blocks
// Purpose: single-precision constants, the divider FSM state type and the
//          zero/inf/nan/normal classifier shared with the multiplier.
// Ports:   none (package).
package fp_pkg;

   localparam int          BIAS    = 127;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {IDLE, DIV, FIN} fp_state_t;

   typedef enum logic [1:0] {FP_ZERO, FP_INF, FP_NAN, FP_NORMAL} fp_class_t;

   // Takes the magnitude bits only; the sign never affects the class.
   // Every exp==0 pattern is zero because denormals are flushed.
   function automatic fp_class_t fp_class(input logic [30:0] x);
      fp_class_t c;
      if (x[30:23] == 8'h00) begin
         c = FP_ZERO;
      end else if (x[30:23] == 8'hFF) begin
         c = (x[22:0] == 23'h0) ? FP_INF : FP_NAN;
      end else begin
         c = FP_NORMAL;
      end
      return c;
   endfunction

endpackage

// File: rtl/mant_divider.sv
// rtl/mant_divider.sv - radix-2 restoring mantissa divider, one quotient bit per clock
// Purpose: divides {1,ma} by {1,mb}, producing MAN_W+2 quotient bits MSB first.
// Ports:   clk, rst_n      clock, async active-low reset
//          load_i          start a new division from ma_i / mb_i
//          step_i          perform one restoring step
//          ma_i, mb_i      stored mantissas of dividend / divisor
//          q_o             quotient bits shifted in so far
//          cnt_o           steps taken; saturates at the last step index
module mant_divider
   import fp_pkg::*;
#(
   parameter int MAN_W = 23
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [MAN_W-1:0]   ma_i,
   input  logic [MAN_W-1:0]   mb_i,
   output logic [MAN_W+1:0]   q_o,
   output logic [4:0]         cnt_o
);

   // Both operands lie in [2^MAN_W, 2^(MAN_W+1)), so the remainder stays
   // below 2*D and one extra bit above the divisor width is enough.
   localparam int         RW   = MAN_W + 2;
   localparam logic [4:0] LAST = 5'(MAN_W + 1);

   logic [RW-1:0]  rem_q, rem_d;
   logic [RW-1:0]  q_q, q_d;
   logic [RW-1:0]  diff;
   logic [MAN_W:0] div_q, div_d;
   logic [4:0]     cnt_q, cnt_d;

   always_comb begin
      rem_d = rem_q;
      div_d = div_q;
      q_d   = q_q;
      cnt_d = cnt_q;
      diff  = rem_q - RW'(div_q);
      if (load_i) begin
         rem_d = RW'({1'b1, ma_i});
         div_d = {1'b1, mb_i};
         q_d   = '0;
         cnt_d = '0;
      end else if (step_i) begin
         if (rem_q >= RW'(div_q)) begin
            rem_d = diff << 1;
            q_d   = {q_q[RW-2:0], 1'b1};
         end else begin
            rem_d = rem_q << 1;
            q_d   = {q_q[RW-2:0], 1'b0};
         end
         if (cnt_q != LAST) begin
            cnt_d = cnt_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         div_q <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         div_q <= div_d;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign q_o   = q_q;
   assign cnt_o = cnt_q;

endmodule

// File: rtl/fp_divider.sv
// rtl/fp_divider.sv - sequential single-precision divider, truncating, denormals flushed
// Purpose: quotient = a / b with a start/busy/done handshake. Owns the FSM,
//          special-case decode, exponent arithmetic and normalisation; the
//          mantissa quotient comes from mant_divider.
// Ports:   clk, rst_n      clock, async active-low reset
//          start           request, sampled only in IDLE
//          a, b            dividend / divisor, captured on the accept edge
//          busy            high from accept edge until done edge
//          done            one-cycle pulse, quotient valid from then on
//          quotient        result, held until the next done
//          div_by_zero     finite nonzero a divided by zero, valid with done
module fp_divider
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int BIAS  = fp_pkg::BIAS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [EXP_W+MAN_W:0]   quotient,
   output logic                   div_by_zero
);

   localparam int                 W         = 1 + EXP_W + MAN_W;
   localparam logic signed [9:0]  BIAS_S    = 10'(BIAS);
   localparam logic signed [9:0]  EXP_MAX   = 10'((1 << EXP_W) - 1);
   localparam logic [4:0]         LAST_STEP = 5'(MAN_W + 1);

   fp_state_t          state_q, state_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d;
   logic [W-1:0]       quo_q, quo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   logic               load, step;
   logic [MAN_W+1:0]   q_mant;
   logic [4:0]         cnt;

   fp_class_t          ca_in, cb_in, ca, cb;
   logic               sgn;
   logic signed [9:0]  e_raw, e_norm;
   logic [MAN_W-1:0]   man;
   logic [W-1:0]       result;
   logic               dbz_res;

   assign ca_in = fp_class(a[W-2:0]);
   assign cb_in = fp_class(b[W-2:0]);
   assign ca    = fp_class(a_q[W-2:0]);
   assign cb    = fp_class(b_q[W-2:0]);

   // Loaded from the live inputs on the accept edge, i.e. the same values
   // captured into a_q / b_q.
   mant_divider #(.MAN_W(MAN_W)) u_mant (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .step_i (step),
      .ma_i   (a[MAN_W-1:0]),
      .mb_i   (b[MAN_W-1:0]),
      .q_o    (q_mant),
      .cnt_o  (cnt)
   );

   // Result assembly from the captured operands; only sampled in FIN.
   always_comb begin
      sgn   = a_q[W-1] ^ b_q[W-1];
      e_raw = $signed(10'(a_q[W-2:MAN_W])) - $signed(10'(b_q[W-2:MAN_W])) + BIAS_S;
      // Mantissa ratio is in (0.5, 2): the top quotient bit tells which half.
      if (q_mant[MAN_W+1]) begin
         man    = q_mant[MAN_W:1];
         e_norm = e_raw;
      end else begin
         man    = q_mant[MAN_W-1:0];
         e_norm = e_raw - 10'sd1;
      end
      dbz_res = (cb == FP_ZERO) && (ca == FP_NORMAL);
      if ((ca == FP_NAN) || (cb == FP_NAN) ||
          ((ca == FP_ZERO) && (cb == FP_ZERO)) ||
          ((ca == FP_INF) && (cb == FP_INF))) begin
         result = QNAN;
      end else if ((cb == FP_ZERO) || (ca == FP_INF)) begin
         result = {sgn, POS_INF[W-2:0]};
      end else if ((ca == FP_ZERO) || (cb == FP_INF)) begin
         result = {sgn, {(W-1){1'b0}}};
      end else if (e_norm >= EXP_MAX) begin
         result = {sgn, POS_INF[W-2:0]};
      end else if (e_norm <= 10'sd0) begin
         result = {sgn, {(W-1){1'b0}}};
      end else begin
         result = {sgn, e_norm[EXP_W-1:0], man};
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      quo_d   = quo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d    = a;
               b_d    = b;
               busy_d = 1'b1;
               load   = 1'b1;
               // Any non-normal operand resolves without the mantissa core.
               state_d = ((ca_in != FP_NORMAL) || (cb_in != FP_NORMAL)) ? FIN : DIV;
            end
         end
         DIV: begin
            step = 1'b1;
            if (cnt == LAST_STEP) begin
               state_d = FIN;
            end
         end
         FIN: begin
            quo_d   = result;
            dbz_d   = dbz_res;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         quo_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         quo_q   <= quo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divider.sv
// tb/tb_fp_divider.sv - randomized self-checking bench for fp_divider
module tb_fp_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp_divider dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_checks++;
      if (obs === want) n_pass++;
      else $display("FAIL %s: observed %h required %h", tag, obs, want);
   endtask

   // Reference: exact integer division of the full mantissas, then the
   // class/priority, exponent and truncation rules applied directly.
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] q, output logic dbz, output int lat);
      int     ex = int'(x[30:23]);
      int     ey = int'(y[30:23]);
      bit     xz = (ex == 0);
      bit     yz = (ey == 0);
      bit     xi = (ex == 255) && (x[22:0] == 23'h0);
      bit     yi = (ey == 255) && (y[22:0] == 23'h0);
      bit     xn = (ex == 255) && (x[22:0] != 23'h0);
      bit     yn = (ey == 255) && (y[22:0] != 23'h0);
      bit     s  = x[31] ^ y[31];
      longint num, den, qq;
      int     e;
      logic [22:0] man;
      dbz = yz && !xz && !xi && !xn;
      lat = (xz || yz || xi || yi || xn || yn) ? 1 : 26;
      if (xn || yn || (xz && yz) || (xi && yi)) q = 32'h7FC00000;
      else if (yz || xi) q = {s, 8'hFF, 23'h0};
      else if (xz || yi) q = {s, 31'h0};
      else begin
         num = (longint'(x[22:0]) + 64'd8388608) * 64'd16777216;
         den = longint'(y[22:0]) + 64'd8388608;
         qq  = num / den;
         e   = ex - ey + 127;
         if (qq >= 64'd16777216) man = 23'((qq / 2) % 64'd8388608);
         else begin
            man = 23'(qq % 64'd8388608);
            e   = e - 1;
         end
         if (e >= 255) q = {s, 8'hFF, 23'h0};
         else if (e <= 0) q = {s, 31'h0};
         else q = {s, 8'(e), man};
      end
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] x   = $urandom;
      int          sel = $urandom_range(0, 15);
      if (sel == 0) x[30:23] = 8'h00;
      else if (sel == 1) x[30:23] = 8'hFF;
      else if (sel == 2) begin
         x[30:23] = 8'hFF;
         x[22:0]  = 23'h0;
      end
      return x;
   endfunction

   // Waits (bounded) for done, sampling 1 time unit after each rising edge.
   task automatic wait_done(output int seen);
      seen = -1000;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = cyc;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag);
      logic [31:0] eq;
      logic        edbz;
      int          elat;
      int          lat;
      bit          busy_ok;
      model(x, y, eq, edbz, elat);
      @(negedge clk);
      start = 1'b1; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      lat = 0; busy_ok = 1'b1;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
      chk({tag, "_q"}, quotient, eq);
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int c0, c1, c2, n_done;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quo", quotient, 32'h0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      run_op(32'h40C00000, 32'h40000000, "six_by_two");
      run_op(32'h3F800000, 32'h40400000, "one_by_three");
      run_op(32'hC1000000, 32'h3F000000, "neg8_by_half");
      run_op(32'h3F800000, 32'h00000000, "one_by_zero");
      run_op(32'h00000000, 32'h00000000, "zero_by_zero");
      run_op(32'h7F800000, 32'h7F800000, "inf_by_inf");
      run_op(32'h80000000, 32'h40000000, "negzero");
      run_op(32'h7F000000, 32'h3E800000, "overflow");
      run_op(32'h00800000, 32'h4B000000, "underflow");
      run_op(32'h7F800000, 32'h00000000, "inf_by_zero");
      run_op(32'h3F800000, 32'h3F800000, "one_by_one");
      run_op(32'h3FFFFFFF, 32'h3F800001, "near_two");

      for (int i = 0; i < 150; i++) run_op(rnd_fp(), rnd_fp(), "rand");

      // start pulsed mid-DIV with other operands is ignored
      @(negedge clk);
      start = 1'b1; a = 32'h40C00000; b = 32'h40000000;
      @(posedge clk); #1;
      start = 1'b0; c0 = cyc;
      repeat (10) @(posedge clk);
      @(negedge clk);
      start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
      @(negedge clk) start = 1'b0;
      wait_done(c1);
      chk("mid_start_lat", c1 - c0, 26);
      chk("mid_start_q", quotient, 32'h40400000);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      chk("mid_start_extra_done", n_done, 0);

      // start held high: back-to-back operations
      @(negedge clk);
      start = 1'b1; a = 32'hC1000000; b = 32'h3F000000;
      wait_done(c1);
      chk("b2b_q1", quotient, 32'hC1800000);
      wait_done(c2);
      start = 1'b0;
      chk("b2b_spacing", c2 - c1, 27);
      chk("b2b_q2", quotient, 32'hC1800000);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_idle", 32'(busy), 32'd0);

      // reset mid-DIV aborts with no done
      @(negedge clk);
      start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_done", 32'(done), 32'd0);
      chk("async_rst_quo", quotient, 32'h0);
      chk("async_rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      chk("rst_abort_no_done", n_done, 0);
      run_op(32'h3F800000, 32'h40400000, "post_rst");
      run_op(32'h40C00000, 32'h40000000, "post_rst2");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
